// File: rtl/tl45_rf_pkg.sv
// rtl/tl45_rf_pkg.sv - shared types and constants for the tl45 register file
package tl45_rf_pkg;

  localparam int RF_ADDR_W   = 4;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  function automatic int rf_nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/tl45_rf_scoreboard.sv
// rtl/tl45_rf_scoreboard.sv - per-register pending-write bits, claim arbitration and pending count
module tl45_rf_scoreboard
  import tl45_rf_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    flush,
  output logic                    claim_ok,
  output logic [(1<<ADDR_W)-1:0]  busy_vec,
  output logic [ADDR_W:0]         pending_cnt
);

  localparam int NREGS = rf_nregs(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  pending_cnt_q, pending_cnt_d;
  logic             wr_live, claim_live, inc, dec;

  always_comb begin
    wr_live    = wr_en && (wr_addr != ZERO);
    claim_ok   = reset && claim_en && !flush &&
                 ((claim_addr == ZERO) || !busy_q[claim_addr] ||
                  (wr_en && (wr_addr == claim_addr)));
    claim_live = claim_ok && (claim_addr != ZERO);
    // a write+claim on the same busy register leaves the bit set, so neither counts
    inc = claim_live && !busy_q[claim_addr];
    dec = wr_live && busy_q[wr_addr] && !(claim_live && (claim_addr == wr_addr));

    busy_d = busy_q;
    if (wr_live)    busy_d[wr_addr]    = 1'b0;
    if (claim_live) busy_d[claim_addr] = 1'b1;
    pending_cnt_d = pending_cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    if (flush) begin
      busy_d        = '0;
      pending_cnt_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign busy_vec    = busy_q;
  assign pending_cnt = pending_cnt_q;

endmodule

// File: rtl/tl45_regfile_sb.sv
// rtl/tl45_regfile_sb.sv - multi-read-port register file with write bypass and integrated scoreboard
module tl45_regfile_sb
  import tl45_rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      claim_en,
  input  logic [ADDR_W-1:0]         claim_addr,
  output logic                      claim_ok,
  input  logic                      flush,
  output logic [(1<<ADDR_W)-1:0]    busy_vec,
  output logic [ADDR_W:0]           pending_cnt
);

  localparam int NREGS = rf_nregs(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

  // flops rather than RAM: the whole array clears on async reset
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != ZERO)) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);
    assign rd_data[g*DATA_W +: DATA_W] = (addr == ZERO) ? '0 :
                                         hit            ? wr_data :
                                                          regs_q[addr];
    // a matching writeback in this cycle is already releasing the register
    assign rd_busy[g] = reset && busy_vec[addr] && !hit;
  end

  tl45_rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .claim_ok    (claim_ok),
    .busy_vec    (busy_vec),
    .pending_cnt (pending_cnt)
  );

endmodule
